// File: rtl/shift_seq_pkg.sv
// Shared definitions for the iterative shift/rotate sequencer:
// operation and state encodings plus default geometry.
package shift_seq_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int AMT_W_DEF    = 4;
    localparam int BIG_STEP_DEF = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Single shared shift stage: rotates or logically shifts by 1 or by BIG_STEP bits.
// Purely combinational; the sequencer iterates it over several cycles.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int BIG_STEP = BIG_STEP_DEF
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic             big,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] rol_1_s, rol_b_s, sll_1_s, sll_b_s;
    logic [WIDTH-1:0] ror_1_s, ror_b_s, srl_1_s, srl_b_s;

    assign rol_1_s = {in[WIDTH-2:0], in[WIDTH-1]};
    assign rol_b_s = {in[WIDTH-BIG_STEP-1:0], in[WIDTH-1 -: BIG_STEP]};
    assign sll_1_s = {in[WIDTH-2:0], 1'b0};
    assign sll_b_s = {in[WIDTH-BIG_STEP-1:0], {BIG_STEP{1'b0}}};
    assign ror_1_s = {in[0], in[WIDTH-1:1]};
    assign ror_b_s = {in[BIG_STEP-1:0], in[WIDTH-1:BIG_STEP]};
    assign srl_1_s = {1'b0, in[WIDTH-1:1]};
    assign srl_b_s = {{BIG_STEP{1'b0}}, in[WIDTH-1:BIG_STEP]};

    // Select the stepped operand by operation and step size.
    always_comb begin
        out = in;
        case (op)
            OP_ROL:  out = big ? rol_b_s : rol_1_s;
            OP_SLL:  out = big ? sll_b_s : sll_1_s;
            OP_ROR:  out = big ? ror_b_s : ror_1_s;
            OP_SRL:  out = big ? srl_b_s : srl_1_s;
            default: out = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shift/rotate unit: accepts {op, data, amount}, walks the shared
// shift_step over several cycles and presents the result on a valid/ready port.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int AMT_W    = AMT_W_DEF,
    parameter int BIG_STEP = BIG_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [AMT_W-1:0] BIG_AMT = AMT_W'(BIG_STEP);
    localparam logic [AMT_W-1:0] ONE_AMT = AMT_W'(1);
    localparam logic [AMT_W-1:0] ZERO_AMT = AMT_W'(0);

    state_e           state_r, state_s;
    op_e              op_r, op_s;
    logic [AMT_W-1:0] rem_r, rem_s;
    logic [WIDTH-1:0] work_r, work_s;
    logic [WIDTH-1:0] out_data_r, out_data_s;
    logic             big_s;
    logic [WIDTH-1:0] step_out_s;
    logic [AMT_W-1:0] rem_dec_s;

    assign big_s     = (rem_r >= BIG_AMT);
    assign rem_dec_s = rem_r - (big_s ? BIG_AMT : ONE_AMT);

    shift_step #(
        .WIDTH    (WIDTH),
        .BIG_STEP (BIG_STEP)
    ) u_step (
        .in  (work_r),
        .op  (op_r),
        .big (big_s),
        .out (step_out_s)
    );

    // Next-state logic; flush overrides both accept and hand-off.
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        rem_s      = rem_r;
        work_s     = work_r;
        out_data_s = out_data_r;
        if (flush) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        op_s   = op_e'(in_op);
                        rem_s  = in_amt;
                        work_s = in_data;
                        if (in_amt == ZERO_AMT) begin
                            state_s    = S_DONE;
                            out_data_s = in_data;
                        end else begin
                            state_s = S_BUSY;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_BUSY: begin
                    work_s = step_out_s;
                    rem_s  = rem_dec_s;
                    if (rem_dec_s == ZERO_AMT) begin
                        state_s    = S_DONE;
                        out_data_s = step_out_s;
                    end else begin
                        state_s = S_BUSY;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_DONE;
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end
    end

    // State, working operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            op_r       <= OP_ROL;
            rem_r      <= ZERO_AMT;
            work_r     <= {WIDTH{1'b0}};
            out_data_r <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            op_r       <= op_s;
            rem_r      <= rem_s;
            work_r     <= work_s;
            out_data_r <= out_data_s;
        end
    end

    assign in_ready  = (state_r == S_IDLE) & ~rst;
    assign out_valid = (state_r == S_DONE);
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed vectors, backpressure,
// reset/flush aborts and a full op x amount sweep against a bit-serial model.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [15:0] in_data = 16'h0000;
    logic [3:0]  in_amt = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;

    shift_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int steps(input int amt);
        return amt / 4 + amt % 4;
    endfunction

    // Bit-serial reference: one single-bit step per unit of amount.
    function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d, input int amt);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < amt; i++) begin
            case (op)
                2'b00:   r = {r[14:0], r[15]};
                2'b01:   r = {r[14:0], 1'b0};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] d,
                          input logic [3:0] amt, input logic [15:0] exp);
        int cyc;
        in_op = op; in_data = d; in_amt = amt; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; in_op = ~op; in_data = ~d; in_amt = ~amt;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, steps(int'(amt)));
        check({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
        tick();
        check({tag, "_taken"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        #2;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        run_op("t1_ror4", OP_ROR, 16'h1234, 4'd4, 16'h4123);
        run_op("t2_rol15", OP_ROL, 16'h8001, 4'd15, 16'hC000);
        run_op("t2_srl15", OP_SRL, 16'h8000, 4'd15, 16'h0001);
        run_op("t2_sll0", OP_SLL, 16'h00FF, 4'd0, 16'h00FF);

        // Backpressure: result must be held while out_ready is low.
        in_op = OP_SLL; in_data = 16'h0001; in_amt = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("bp_early", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b1; in_data = 16'hDEAD; in_amt = 4'd0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", {16'd0, out_data}, 32'h0008);
            check("bp_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_taken", {31'd0, out_valid}, 32'd0);
        check("bp_idle", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-BUSY.
        in_op = OP_ROR; in_data = 16'hFFFF; in_amt = 4'd13; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        #1 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_data", {16'd0, out_data}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("arst_no_result", {31'd0, seen}, 32'd0);
        run_op("arst_next", OP_ROL, 16'h0001, 4'd1, 16'h0002);

        // Flush in IDLE competes with a request: request must not be taken.
        in_op = OP_SLL; in_data = 16'h1234; in_amt = 4'd0; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_idle_ready", {31'd0, in_ready}, 32'd1);
        check("fl_idle_valid", {31'd0, out_valid}, 32'd0);

        // Flush in BUSY with a new request pending.
        in_op = OP_SRL; in_data = 16'hFFFF; in_amt = 4'd15; in_valid = 1'b1;
        tick();
        in_amt = 4'd0; in_data = 16'h1234; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_busy_ready", {31'd0, in_ready}, 32'd1);
        check("fl_busy_valid", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("fl_busy_no_result", {31'd0, seen}, 32'd0);

        // Flush in DONE drops the pending result.
        out_ready = 1'b0;
        in_op = OP_SLL; in_data = 16'h0001; in_amt = 4'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("fl_done_pre", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_done_valid", {31'd0, out_valid}, 32'd0);
        check("fl_done_ready", {31'd0, in_ready}, 32'd1);

        // Sweep every op x amount with random operands.
        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 16; a++) begin
                logic [15:0] d;
                d = 16'($urandom);
                run_op($sformatf("sw_op%0d_amt%0d", op, a), 2'(op), d, 4'(a),
                       ref_shift(2'(op), d, a));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
